// File: rtl/sw_led_ctrl.sv
// Switch front end: two-flop synchroniser, per-bit debounce, rising-edge pulses,
// and a registered LED driver with mirror/toggle/blink/invert display modes.
module sw_led_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEB_CNT   = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise
);

    localparam int CW = (DEB_CNT   > 1) ? $clog2(DEB_CNT)   : 1;
    localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CNT - 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(BLINK_DIV - 1);

    localparam logic [1:0] MODE_MIRROR = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_INVERT = 2'b11;

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] tog_q, tog_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             phase_q, phase_d;
    logic [WIDTH-1:0] led_q, led_d;

    // Each bit debounces independently; a return to the stable level restarts its count.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DEB_MAX) begin
                    stable_d[i] = s2_q[i];
                    rise_d[i]   = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        tog_d = tog_q ^ rise_q;
        if (pre_q == PRE_MAX) begin
            pre_d   = '0;
            phase_d = ~phase_q;
        end else begin
            pre_d   = pre_q + 1'b1;
            phase_d = phase_q;
        end
    end

    always_comb begin
        led_d = '0;
        case (mode)
            MODE_MIRROR: led_d = stable_q;
            MODE_TOGGLE: led_d = tog_q;
            MODE_BLINK:  led_d = stable_q & {WIDTH{phase_q}};
            MODE_INVERT: led_d = ~stable_q;
            default:     led_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            tog_q    <= '0;
            pre_q    <= '0;
            phase_q  <= 1'b0;
            led_q    <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= switch;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            tog_q    <= tog_d;
            pre_q    <= pre_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign led       = led_q;
    assign sw_stable = stable_q;
    assign sw_rise   = rise_q;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Directed bench for sw_led_ctrl with WIDTH=8, DEB_CNT=4, BLINK_DIV=3.
module tb_sw_led_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] switch = 8'h00;
    logic [1:0] mode = 2'b00;
    logic [7:0] led, sw_stable, sw_rise;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] sw;
        logic [1:0] md;
        logic [7:0] exp_stable;
        logic [7:0] exp_led;
    } vec_t;

    vec_t vecs [11];

    sw_led_ctrl #(.WIDTH(8), .DEB_CNT(4), .BLINK_DIV(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .switch    (switch),
        .mode      (mode),
        .led       (led),
        .sw_stable (sw_stable),
        .sw_rise   (sw_rise)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        int rises;

        // steady-state vectors, applied in order from a clean reset with switch=0
        vecs[0]  = '{8'h00, 2'b00, 8'h00, 8'h00};
        vecs[1]  = '{8'hA5, 2'b00, 8'hA5, 8'hA5};
        vecs[2]  = '{8'hA5, 2'b11, 8'hA5, 8'h5A};
        vecs[3]  = '{8'h3C, 2'b11, 8'h3C, 8'hC3};
        vecs[4]  = '{8'h3C, 2'b01, 8'h3C, 8'hBD};
        vecs[5]  = '{8'hFF, 2'b01, 8'hFF, 8'h7E};
        vecs[6]  = '{8'h00, 2'b01, 8'h00, 8'h7E};
        vecs[7]  = '{8'h01, 2'b01, 8'h01, 8'h7F};
        vecs[8]  = '{8'h01, 2'b00, 8'h01, 8'h01};
        vecs[9]  = '{8'h80, 2'b11, 8'h80, 8'h7F};
        vecs[10] = '{8'h80, 2'b01, 8'h80, 8'hFF};

        // 1: reset values and post-reset latency
        @(negedge clk);
        switch = 8'hFF;
        mode   = 2'b00;
        do_reset();
        check("rst_led", led, 8'h00);
        check("rst_stable", sw_stable, 8'h00);
        check("rst_rise", sw_rise, 8'h00);
        step(5);
        check("t1_stable_e5", sw_stable, 8'h00);
        step(1);
        check("t1_stable_e6", sw_stable, 8'hFF);
        check("t1_rise_e6", sw_rise, 8'hFF);
        check("t1_led_e6", led, 8'h00);
        step(1);
        check("t1_led_e7", led, 8'hFF);
        check("t1_rise_e7", sw_rise, 8'h00);

        // table
        switch = 8'h00;
        do_reset();
        for (int v = 0; v < 11; v++) begin
            switch = vecs[v].sw;
            mode   = vecs[v].md;
            step(12);
            check($sformatf("vec%0d_stable", v), sw_stable, vecs[v].exp_stable);
            check($sformatf("vec%0d_led", v), led, vecs[v].exp_led);
        end

        // 2: 3-cycle glitch rejected, 4+ cycle level accepted
        switch = 8'h00;
        mode   = 2'b00;
        do_reset();
        step(3);
        switch = 8'h01;
        step(3);
        switch = 8'h00;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check("t2_glitch_stable", sw_stable, 8'h00);
            check("t2_glitch_rise", sw_rise, 8'h00);
        end
        check("t2_glitch_led", led, 8'h00);
        switch = 8'h01;
        step(5);
        check("t2_stable_e5", sw_stable, 8'h00);
        step(1);
        check("t2_stable_e6", sw_stable, 8'h01);
        check("t2_rise_e6", sw_rise, 8'h01);
        step(1);
        check("t2_rise_e7", sw_rise, 8'h00);
        check("t2_led_e7", led, 8'h01);

        // 3: toggle mode with two presses of switch[3]
        switch = 8'h00;
        mode   = 2'b01;
        do_reset();
        step(3);
        rises = 0;
        for (int p = 0; p < 4; p++) begin
            switch = (p % 2 == 0) ? 8'h08 : 8'h00;
            for (int k = 0; k < 10; k++) begin
                step(1);
                if (sw_rise[3]) rises++;
                check("t3_rise_other_bits", sw_rise & 8'hF7, 8'h00);
            end
            check($sformatf("t3_led_phase%0d", p), led, (p < 2) ? 8'h08 : 8'h00);
        end
        check("t3_rise_count", 8'(rises), 8'd2);

        // 4: blink, period 6 once stable
        switch = 8'h81;
        mode   = 2'b10;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            step(1);
            if (k >= 7)
                check($sformatf("t4_blink_e%0d", k), led, (((k - 1) / 3) % 2 == 1) ? 8'h81 : 8'h00);
        end

        // 5: invert, then mirror
        switch = 8'h0F;
        mode   = 2'b11;
        do_reset();
        step(1);
        check("t5_led_e1", led, 8'hFF);
        step(9);
        check("t5_led_inv", led, 8'hF0);
        mode = 2'b00;
        check("t5_led_before_edge", led, 8'hF0);
        step(1);
        check("t5_led_mirror", led, 8'h0F);

        // 6: reset mid-debounce discards progress
        switch = 8'h00;
        mode   = 2'b00;
        do_reset();
        step(3);
        switch = 8'h20;
        step(3);
        check("t6_pre_rst_stable", sw_stable, 8'h00);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_rst_stable", sw_stable, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check($sformatf("t6_stable_e%0d", k), sw_stable, 8'h00);
        end
        step(1);
        check("t6_stable_e6", sw_stable, 8'h20);
        check("t6_rise_e6", sw_rise, 8'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
